// File: rtl/vu_level_scheduler_if.sv
// Sample/frame handshake bundle between the UART byte path, the level
// scheduler and the VGA image path.
interface vu_level_scheduler_if #(
    parameter int DATA_W = 8
);
    logic              enable;
    logic [DATA_W-1:0] data_in;
    logic              load;
    logic              error;
    logic              frame_start;
    logic [DATA_W-1:0] level;
    logic [DATA_W-1:0] peak;
    logic              update;
    logic              busy;
    logic [7:0]        err_count;
    logic [7:0]        miss_count;

    modport master (
        output enable, data_in, load, error, frame_start,
        input  level, peak, update, busy, err_count, miss_count
    );

    modport slave (
        input  enable, data_in, load, error, frame_start,
        output level, peak, update, busy, err_count, miss_count
    );
endinterface

// File: rtl/vu_level_scheduler.sv
// Frame-rate VU bar controller: captures sample bytes, then once per frame
// computes an instant-attack/linear-decay level and a peak-hold marker.
module vu_level_scheduler #(
    parameter int DATA_W         = 8,
    parameter int DECAY_STEP     = 4,
    parameter int PEAK_DECAY     = 2,
    parameter int HOLD_FRAMES    = 30,
    parameter int TIMEOUT_FRAMES = 60,
    parameter int CNT_W          = 6
) (
    input  logic                  clock,
    input  logic                  reset,
    vu_level_scheduler_if.slave   bus
);
    localparam logic [1:0] IDLE       = 2'd0;
    localparam logic [1:0] CALC_LEVEL = 2'd1;
    localparam logic [1:0] CALC_PEAK  = 2'd2;
    localparam logic [1:0] PUBLISH    = 2'd3;

    localparam logic [DATA_W-1:0] LVL_STEP = DATA_W'(DECAY_STEP);
    localparam logic [DATA_W-1:0] PK_STEP  = DATA_W'(PEAK_DECAY);
    localparam logic [CNT_W-1:0]  HOLD_MAX = CNT_W'(HOLD_FRAMES);
    localparam logic [CNT_W-1:0]  TO_MAX   = CNT_W'(TIMEOUT_FRAMES);

    logic [1:0]        state;
    logic [DATA_W-1:0] target;
    logic [CNT_W-1:0]  timeout_cnt;
    logic [CNT_W-1:0]  hold_cnt;
    logic [DATA_W-1:0] lvl_n;
    logic [DATA_W-1:0] pk_n;
    logic [DATA_W-1:0] level_q;
    logic [DATA_W-1:0] peak_q;
    logic              update_q;
    logic [7:0]        err_cnt_q;
    logic [7:0]        miss_cnt_q;

    logic [DATA_W-1:0] t_snap;
    logic [DATA_W-1:0] lvl_dec;
    logic [DATA_W-1:0] lvl_calc;
    logic [DATA_W-1:0] pk_dec;
    logic [DATA_W-1:0] pk_calc;
    logic              good_load;

    assign good_load = bus.load && !bus.error;

    // NOTE: every always_comb output gets a value on every path, so no latches are inferred.
    always_comb begin
        t_snap   = (timeout_cnt == TO_MAX) ? '0 : target;
        lvl_dec  = (level_q > LVL_STEP) ? level_q - LVL_STEP : '0;
        lvl_calc = t_snap;
        if (t_snap < level_q && lvl_dec > t_snap)
            lvl_calc = lvl_dec;
        pk_dec  = (peak_q > PK_STEP) ? peak_q - PK_STEP : '0;
        pk_calc = (pk_dec > lvl_n) ? pk_dec : lvl_n;
        if (lvl_n >= peak_q)
            pk_calc = lvl_n;
        else if (hold_cnt != '0)
            pk_calc = peak_q;
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            target      <= '0;
            timeout_cnt <= '0;
            hold_cnt    <= '0;
            lvl_n       <= '0;
            pk_n        <= '0;
            level_q     <= '0;
            peak_q      <= '0;
            update_q    <= 1'b0;
            err_cnt_q   <= '0;
            miss_cnt_q  <= '0;
        end else if (bus.enable) begin
            update_q <= 1'b0;

            if (good_load)
                target <= bus.data_in;
            if (bus.load && bus.error && err_cnt_q != 8'hFF)
                err_cnt_q <= err_cnt_q + 8'd1;

            // A fresh sample restarts the timeout even while a frame is being computed.
            if (good_load)
                timeout_cnt <= '0;
            else if (state == CALC_LEVEL && timeout_cnt != TO_MAX)
                timeout_cnt <= timeout_cnt + 1'b1;

            if (bus.frame_start && state != IDLE && miss_cnt_q != 8'hFF)
                miss_cnt_q <= miss_cnt_q + 8'd1;

            case (state)
                IDLE: begin
                    if (bus.frame_start)
                        state <= CALC_LEVEL;
                end
                CALC_LEVEL: begin
                    lvl_n <= lvl_calc;
                    state <= CALC_PEAK;
                end
                CALC_PEAK: begin
                    pk_n <= pk_calc;
                    if (lvl_n >= peak_q)
                        hold_cnt <= HOLD_MAX;
                    else if (hold_cnt != '0)
                        hold_cnt <= hold_cnt - 1'b1;
                    state <= PUBLISH;
                end
                default: begin
                    level_q  <= lvl_n;
                    peak_q   <= pk_n;
                    update_q <= 1'b1;
                    state    <= IDLE;
                end
            endcase
        end
    end

    assign bus.level      = level_q;
    assign bus.peak       = peak_q;
    assign bus.update     = update_q && bus.enable;
    assign bus.busy       = (state != IDLE);
    assign bus.err_count  = err_cnt_q;
    assign bus.miss_count = miss_cnt_q;
endmodule

// File: tb/tb_vu_level_scheduler.sv
// Directed bench for vu_level_scheduler: reset, attack, decay/hold, timeout,
// error/miss counting, coincident load and mid-frame freeze.
module tb_vu_level_scheduler;
    logic clock = 1'b0;
    logic reset = 1'b0;
    int   n_checks = 0;
    int   n_pass = 0;

    vu_level_scheduler_if #(.DATA_W(8)) bus ();

    vu_level_scheduler dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic load_byte(input logic [7:0] d, input logic err);
        bus.data_in = d;
        bus.load    = 1'b1;
        bus.error   = err;
        tick();
        bus.load    = 1'b0;
        bus.error   = 1'b0;
    endtask

    // One frame: the new values must appear with update exactly 3 edges after the accepted edge.
    task automatic run_frame(input logic [7:0] lvl_e, input logic [7:0] pk_e,
                             input bit chk_pk, input string tag);
        bus.frame_start = 1'b1;
        tick();
        bus.frame_start = 1'b0;
        bus.load        = 1'b0;
        tick();
        tick();
        check({tag, "_early_upd"}, 32'(bus.update), 32'd0);
        tick();
        check({tag, "_upd"}, 32'(bus.update), 32'd1);
        check({tag, "_level"}, 32'(bus.level), 32'(lvl_e));
        if (chk_pk)
            check({tag, "_peak"}, 32'(bus.peak), 32'(pk_e));
        tick();
        check({tag, "_upd_clr"}, 32'(bus.update), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int v;
        int n_upd;
        int n_cyc;
        bus.enable      = 1'b1;
        bus.data_in     = '0;
        bus.load        = 1'b0;
        bus.error       = 1'b0;
        bus.frame_start = 1'b0;

        // Reset state
        tick();
        tick();
        check("rst_level", 32'(bus.level), 32'd0);
        check("rst_peak", 32'(bus.peak), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_upd", 32'(bus.update), 32'd0);
        reset = 1'b1;
        tick();

        // Reset mid-CALC_PEAK discards the frame in flight
        load_byte(8'h40, 1'b0);
        run_frame(8'h40, 8'h40, 1'b1, "pre");
        load_byte(8'h90, 1'b0);
        bus.frame_start = 1'b1;
        tick();
        bus.frame_start = 1'b0;
        tick();
        check("midpk_busy", 32'(bus.busy), 32'd1);
        reset = 1'b0;
        #1;
        check("midrst_level", 32'(bus.level), 32'd0);
        check("midrst_peak", 32'(bus.peak), 32'd0);
        check("midrst_busy", 32'(bus.busy), 32'd0);
        check("midrst_upd", 32'(bus.update), 32'd0);
        tick();
        reset = 1'b1;
        n_upd = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (bus.update) n_upd++;
        end
        check("midrst_no_pub", 32'(n_upd), 32'd0);
        check("midrst_level2", 32'(bus.level), 32'd0);
        run_frame(8'h00, 8'h00, 1'b1, "rst_target");

        // Attack
        load_byte(8'hC8, 1'b0);
        run_frame(8'hC8, 8'hC8, 1'b1, "attack");

        // Decay to floor 0x10; peak held 30 frames then falls 2 per frame
        load_byte(8'h10, 1'b0);
        for (int k = 1; k <= 50; k++) begin
            v = 200 - 4 * k;
            if (v < 16) v = 16;
            run_frame(8'(v), (k <= 30) ? 8'd200 : 8'(200 - 2 * (k - 30)), 1'b1,
                      $sformatf("decay%0d", k));
        end

        // Timeout: level stays at 0x50 for 60 frames, then target is forced to 0
        load_byte(8'h50, 1'b0);
        for (int j = 1; j <= 60; j++)
            run_frame(8'h50, (j < 40) ? 8'(160 - 2 * j) : 8'd80, 1'b1,
                      $sformatf("to%0d", j));
        for (int j = 61; j <= 80; j++)
            run_frame(8'(80 - 4 * (j - 60)), 8'd80, 1'b1, $sformatf("tod%0d", j));
        load_byte(8'h20, 1'b0);
        run_frame(8'h20, 8'd80, 1'b1, "restart");

        // Corrupt bytes counted, target kept
        for (int e = 0; e < 3; e++)
            load_byte(8'hFF, 1'b1);
        check("err_count", 32'(bus.err_count), 32'd3);
        run_frame(8'h20, 8'd80, 1'b1, "err_keep");

        // frame_start during busy cycles 1 and 2
        bus.frame_start = 1'b1;
        tick();
        tick();
        tick();
        bus.frame_start = 1'b0;
        n_upd = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (bus.update) n_upd++;
        end
        check("miss_count", 32'(bus.miss_count), 32'd2);
        check("miss_one_upd", 32'(n_upd), 32'd1);
        check("miss_level", 32'(bus.level), 32'h20);

        // Load coincident with accepted frame_start is used
        bus.data_in = 8'h80;
        bus.load    = 1'b1;
        run_frame(8'h80, 8'h80, 1'b1, "coinc");

        // Freeze 5 cycles mid-FSM; corrupt byte during freeze is ignored
        load_byte(8'h60, 1'b0);
        bus.frame_start = 1'b1;
        tick();
        bus.frame_start = 1'b0;
        tick();
        bus.enable = 1'b0;
        bus.load   = 1'b1;
        bus.error  = 1'b1;
        n_upd = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            bus.load  = 1'b0;
            bus.error = 1'b0;
            if (bus.update || !bus.busy) n_upd++;
        end
        check("freeze_hold", 32'(n_upd), 32'd0);
        bus.enable = 1'b1;
        n_cyc = 6;
        for (int i = 0; i < 10; i++) begin
            tick();
            n_cyc++;
            if (bus.update) break;
        end
        check("freeze_delay", 32'(n_cyc), 32'd8);
        check("freeze_level", 32'(bus.level), 32'd124);
        check("freeze_peak", 32'(bus.peak), 32'd128);
        check("freeze_err", 32'(bus.err_count), 32'd3);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
